// File: rtl/sudoku_pkg.sv
// Shared constants, state encoding and value check for the sudoku grid access path.
package sudoku_pkg;

   localparam int unsigned N      = 9;
   localparam int unsigned CELLS  = 81;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned VAL_W  = 4;

   localparam logic [VAL_W-1:0]  EMPTY     = '0;
   localparam logic [VAL_W-1:0]  MAX_VAL   = VAL_W'(N);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
   localparam logic [3:0]        LAST_IDX  = 4'(N - 1);

   typedef enum logic [1:0] {
      StClear,
      StEdit,
      StSolve,
      StView
   } state_e;

   function automatic logic val_legal(input logic [VAL_W-1:0] v);
      return v <= MAX_VAL;
   endfunction

endpackage

// File: rtl/grid_cursor.sv
// Row/column cursor with a registered linear address that tracks row*9+col by counting,
// wrapping (8,8)<->(0,0). Simultaneous inc and dec leave it in place.
module grid_cursor
   import sudoku_pkg::*;
(
   input  logic              board_clk,
   input  logic              Reset,
   input  logic              inc,
   input  logic              dec,
   output logic [3:0]        row,
   output logic [3:0]        col,
   output logic [ADDR_W-1:0] addr
);

   logic [3:0]        row_q, row_d;
   logic [3:0]        col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   always_comb begin
      row_d  = row_q;
      col_d  = col_q;
      addr_d = addr_q;
      if (inc && !dec) begin
         addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
         if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = (row_q == LAST_IDX) ? '0 : row_q + 4'd1;
         end else begin
            col_d = col_q + 4'd1;
         end
      end else if (dec && !inc) begin
         addr_d = (addr_q == '0) ? LAST_ADDR : addr_q - 1'b1;
         if (col_q == '0) begin
            col_d = LAST_IDX;
            row_d = (row_q == '0) ? LAST_IDX : row_q - 4'd1;
         end else begin
            col_d = col_q - 4'd1;
         end
      end
   end

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         row_q  <= '0;
         col_q  <= '0;
         addr_q <= '0;
      end else begin
         row_q  <= row_d;
         col_q  <= col_d;
         addr_q <= addr_d;
      end
   end

   assign row  = row_q;
   assign col  = col_q;
   assign addr = addr_q;

endmodule

// File: rtl/grid_access_ctrl.sv
// Arbitrates the single grid RAM port between the clear sweep, the user cursor/editor and
// the solver, and sequences CLEAR -> EDIT -> SOLVE -> VIEW.
module grid_access_ctrl
   import sudoku_pkg::*;
(
   input  logic              board_clk,
   input  logic              Reset,
   input  logic              Prev,
   input  logic              Next,
   input  logic              Enter,
   input  logic              Start,
   input  logic [VAL_W-1:0]  InputValue,
   input  logic              slv_req,
   input  logic              slv_we,
   input  logic [ADDR_W-1:0] slv_addr,
   input  logic [VAL_W-1:0]  slv_wdata,
   output logic              slv_gnt,
   output logic [VAL_W-1:0]  slv_rdata,
   output logic              slv_rvalid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [VAL_W-1:0]  mem_wdata,
   input  logic [VAL_W-1:0]  mem_rdata,
   output logic              solve_go,
   input  logic              solve_done,
   output logic [3:0]        Row,
   output logic [3:0]        Col,
   output logic [VAL_W-1:0]  CellValue,
   output logic              Busy,
   output logic              InErr
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [VAL_W-1:0]  cell_q;
   logic              rvalid_q;
   logic              ui_rd, ui_rd_q;
   logic              cur_inc, cur_dec;
   logic [ADDR_W-1:0] cur_addr;

   grid_cursor u_cursor (
      .board_clk (board_clk),
      .Reset     (Reset),
      .inc       (cur_inc),
      .dec       (cur_dec),
      .row       (Row),
      .col       (Col),
      .addr      (cur_addr)
   );

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      mem_we    = 1'b0;
      mem_addr  = cur_addr;
      mem_wdata = EMPTY;
      slv_gnt   = 1'b0;
      solve_go  = 1'b0;
      InErr     = 1'b0;
      cur_inc   = 1'b0;
      cur_dec   = 1'b0;
      ui_rd     = 1'b0;
      unique case (state_q)
         StClear: begin
            mem_we    = 1'b1;
            mem_addr  = clr_cnt_q;
            mem_wdata = EMPTY;
            if (clr_cnt_q == LAST_ADDR) begin
               clr_cnt_d = '0;
               state_d   = StEdit;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         StEdit: begin
            cur_inc = Next && !Prev;
            cur_dec = Prev && !Next;
            // Write uses the current (pre-move) cursor address.
            if (Enter) begin
               if (val_legal(InputValue)) begin
                  mem_we    = 1'b1;
                  mem_wdata = InputValue;
               end else begin
                  InErr = 1'b1;
               end
            end
            if (Start) begin
               solve_go = 1'b1;
               state_d  = StSolve;
            end
            ui_rd = !mem_we;
         end
         StSolve: begin
            slv_gnt = slv_req;
            if (slv_req) begin
               mem_we    = slv_we;
               mem_addr  = slv_addr;
               mem_wdata = slv_wdata;
            end else begin
               ui_rd = 1'b1;
            end
            if (solve_done) begin
               state_d = StView;
            end
         end
         StView: begin
            cur_inc = Next && !Prev;
            cur_dec = Prev && !Next;
            ui_rd   = 1'b1;
            if (Start) begin
               state_d = StEdit;
            end
         end
      endcase
      // Outputs must be quiet while reset is held, not just after the next edge.
      if (Reset) begin
         mem_we   = 1'b0;
         slv_gnt  = 1'b0;
         solve_go = 1'b0;
         InErr    = 1'b0;
         ui_rd    = 1'b0;
      end
   end

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= StClear;
         clr_cnt_q <= '0;
         cell_q    <= EMPTY;
         rvalid_q  <= 1'b0;
         ui_rd_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         rvalid_q  <= slv_gnt && !slv_we;
         ui_rd_q   <= ui_rd;
         if (ui_rd_q) begin
            cell_q <= mem_rdata;
         end
      end
   end

   assign slv_rdata  = mem_rdata;
   assign slv_rvalid = rvalid_q;
   assign CellValue  = cell_q;
   assign Busy       = (state_q == StClear) || (state_q == StSolve);

endmodule

// File: tb/tb_grid_access_ctrl.sv
// Self-checking bench for grid_access_ctrl with a behavioural synchronous-read grid RAM.
module tb_grid_access_ctrl;

   logic       board_clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Prev = 1'b0, Next = 1'b0, Enter = 1'b0, Start = 1'b0;
   logic [3:0] InputValue = '0;
   logic       slv_req = 1'b0, slv_we = 1'b0;
   logic [6:0] slv_addr = '0;
   logic [3:0] slv_wdata = '0;
   logic       slv_gnt, slv_rvalid, mem_we, solve_go, Busy, InErr;
   logic [3:0] slv_rdata, mem_wdata, Row, Col, CellValue;
   logic [6:0] mem_addr;
   logic [3:0] mem_rdata = '0;
   logic       solve_done = 1'b0;

   int checks = 0;
   int errors = 0;
   int sb[$];

   bit [3:0] ram[128];
   bit       written[128];

   grid_access_ctrl dut (
      .board_clk  (board_clk),
      .Reset      (Reset),
      .Prev       (Prev),
      .Next       (Next),
      .Enter      (Enter),
      .Start      (Start),
      .InputValue (InputValue),
      .slv_req    (slv_req),
      .slv_we     (slv_we),
      .slv_addr   (slv_addr),
      .slv_wdata  (slv_wdata),
      .slv_gnt    (slv_gnt),
      .slv_rdata  (slv_rdata),
      .slv_rvalid (slv_rvalid),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .solve_go   (solve_go),
      .solve_done (solve_done),
      .Row        (Row),
      .Col        (Col),
      .CellValue  (CellValue),
      .Busy       (Busy),
      .InErr      (InErr)
   );

   always #5 board_clk = ~board_clk;

   // Unwritten cells read as 15 so a missed clear is visible.
   always @(posedge board_clk) begin
      if (mem_we) begin
         ram[mem_addr]     <= mem_wdata;
         written[mem_addr] <= 1'b1;
      end
      mem_rdata <= written[mem_addr] ? ram[mem_addr] : 4'hF;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge board_clk) begin
      if (slv_rvalid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_rvalid: got rvalid=1 expected none at %0t", $time);
         end else begin
            chk("sb_rdata", slv_rdata, sb.pop_front());
         end
      end
   end

   task automatic drive(input logic p, input logic n, input logic e, input logic s,
                        input logic [3:0] v);
      @(negedge board_clk);
      Prev = p; Next = n; Enter = e; Start = s; InputValue = v;
      solve_done = 1'b0; slv_req = 1'b0; slv_we = 1'b0;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
   endtask

   // Entered right after reset release; UI inputs are hammered to show they are ignored.
   task automatic check_clear();
      for (int i = 0; i < 81; i++) begin
         if (i > 0) @(negedge board_clk);
         Prev = (i % 2 == 1) && (i < 80);
         Next = (i % 2 == 0) && (i < 80);
         Enter = (i < 80);
         Start = (i < 80);
         InputValue = 4'd12;
         #1;
         chk("clr_we", mem_we, 1);
         chk("clr_addr", mem_addr, i);
         chk("clr_wdata", mem_wdata, 0);
         chk("clr_busy", Busy, 1);
         chk("clr_inerr", InErr, 0);
         chk("clr_go", solve_go, 0);
      end
      idle();
      chk("clr_end_we", mem_we, 0);
      chk("clr_end_busy", Busy, 0);
      chk("clr_end_row", Row, 0);
      chk("clr_end_col", Col, 0);
      chk("clr_end_addr", mem_addr, 0);
   endtask

   typedef struct {
      logic       prev, next, enter;
      logic [3:0] val;
      logic       exp_we;
      logic [6:0] exp_addr;
      logic [3:0] exp_wdata;
      logic       exp_err;
      logic [3:0] exp_row, exp_col;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{0, 1, 0, 4'd0,  0, 7'd80, 4'd0, 0, 4'd0, 4'd0};
      vecs[1]  = '{1, 1, 0, 4'd0,  0, 7'd0,  4'd0, 0, 4'd0, 4'd0};
      vecs[2]  = '{0, 1, 0, 4'd0,  0, 7'd0,  4'd0, 0, 4'd0, 4'd1};
      vecs[3]  = '{0, 1, 1, 4'd3,  1, 7'd1,  4'd3, 0, 4'd0, 4'd2};
      vecs[4]  = '{0, 0, 1, 4'd12, 0, 7'd2,  4'd0, 1, 4'd0, 4'd2};
      vecs[5]  = '{1, 0, 0, 4'd0,  0, 7'd2,  4'd0, 0, 4'd0, 4'd1};
      vecs[6]  = '{1, 0, 1, 4'd9,  1, 7'd1,  4'd9, 0, 4'd0, 4'd0};
      vecs[7]  = '{1, 0, 0, 4'd0,  0, 7'd0,  4'd0, 0, 4'd8, 4'd8};
      vecs[8]  = '{0, 0, 1, 4'd0,  1, 7'd80, 4'd0, 0, 4'd8, 4'd8};
      vecs[9]  = '{0, 1, 0, 4'd0,  0, 7'd80, 4'd0, 0, 4'd0, 4'd0};
      vecs[10] = '{0, 0, 1, 4'd10, 0, 7'd0,  4'd0, 1, 4'd0, 4'd0};

      // Reset state
      @(negedge board_clk);
      #1;
      chk("rst_we", mem_we, 0);
      chk("rst_busy", Busy, 1);
      chk("rst_gnt", slv_gnt, 0);
      chk("rst_rvalid", slv_rvalid, 0);
      chk("rst_go", solve_go, 0);
      chk("rst_inerr", InErr, 0);
      chk("rst_row", Row, 0);
      chk("rst_col", Col, 0);
      chk("rst_cell", CellValue, 0);
      @(negedge board_clk);
      Reset = 1'b0;
      check_clear();

      // Full forward sweep and both wraps
      for (int i = 0; i < 80; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      idle();
      chk("sweep_row", Row, 8);
      chk("sweep_col", Col, 8);
      chk("sweep_addr", mem_addr, 80);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      idle();
      chk("wrap_fwd_row", Row, 0);
      chk("wrap_fwd_col", Col, 0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      idle();
      chk("wrap_back_row", Row, 8);
      chk("wrap_back_col", Col, 8);
      chk("wrap_back_addr", mem_addr, 80);

      foreach (vecs[k]) begin
         drive(vecs[k].prev, vecs[k].next, vecs[k].enter, 1'b0, vecs[k].val);
         chk($sformatf("vec%0d_we", k), mem_we, vecs[k].exp_we);
         chk($sformatf("vec%0d_addr", k), mem_addr, vecs[k].exp_addr);
         chk($sformatf("vec%0d_err", k), InErr, vecs[k].exp_err);
         if (vecs[k].exp_we) chk($sformatf("vec%0d_wdata", k), mem_wdata, vecs[k].exp_wdata);
         idle();
         chk($sformatf("vec%0d_row", k), Row, vecs[k].exp_row);
         chk($sformatf("vec%0d_col", k), Col, vecs[k].exp_col);
      end

      // Move to (2,3); stray solve_done in EDIT must not change state
      for (int i = 0; i < 21; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      idle();
      chk("c23_row", Row, 2);
      chk("c23_col", Col, 3);
      chk("c23_addr", mem_addr, 21);
      @(negedge board_clk);
      solve_done = 1'b1;
      #1;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd7);
      chk("w7_we", mem_we, 1);
      chk("w7_addr", mem_addr, 21);
      chk("w7_data", mem_wdata, 7);
      chk("w7_busy", Busy, 0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd12);
      chk("w12_we", mem_we, 0);
      chk("w12_err", InErr, 1);
      idle();
      chk("err_pulse_end", InErr, 0);
      idle();
      idle();
      chk("cell_after_w7", CellValue, 7);

      // Solve
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      chk("go_pulse", solve_go, 1);
      idle();
      chk("go_end", solve_go, 0);
      chk("solve_busy", Busy, 1);
      @(negedge board_clk);
      Enter = 1'b1; Next = 1'b1; InputValue = 4'd5;
      slv_req = 1'b1; slv_we = 1'b0; slv_addr = 7'd21;
      #1;
      chk("sr21_gnt", slv_gnt, 1);
      chk("sr21_addr", mem_addr, 21);
      chk("sr21_we", mem_we, 0);
      sb.push_back(7);
      @(negedge board_clk);
      slv_we = 1'b1; slv_addr = 7'd40; slv_wdata = 4'd9;
      #1;
      chk("sw40_we", mem_we, 1);
      chk("sw40_addr", mem_addr, 40);
      chk("sw40_data", mem_wdata, 9);
      @(negedge board_clk);
      slv_we = 1'b0;
      #1;
      chk("sr40_gnt", slv_gnt, 1);
      sb.push_back(9);
      @(negedge board_clk);
      slv_addr = 7'd85;
      #1;
      chk("sr85_addr", mem_addr, 85);
      sb.push_back(15);
      idle();
      chk("nogrant_gnt", slv_gnt, 0);
      chk("nogrant_addr", mem_addr, 21);
      chk("solve_row", Row, 2);
      chk("solve_col", Col, 3);
      idle();
      chk("solve_busy2", Busy, 1);
      @(negedge board_clk);
      solve_done = 1'b1;
      #1;
      idle();
      chk("view_busy", Busy, 0);
      chk("view_row", Row, 2);
      chk("view_col", Col, 3);

      // View
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
      chk("view_enter_we", mem_we, 0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      idle();
      chk("view_next_col", Col, 4);
      idle();
      idle();
      chk("view_cell22", CellValue, 0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      idle();
      idle();
      idle();
      chk("view_cell21", CellValue, 7);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      chk("view_start_go", solve_go, 0);
      idle();
      chk("back_edit_busy", Busy, 0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd12);
      chk("back_edit_err", InErr, 1);
      idle();
      idle();
      chk("back_edit_cell", CellValue, 7);

      // Reset mid-SOLVE
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      idle();
      @(negedge board_clk);
      slv_req = 1'b1; slv_addr = 7'd10;
      #1;
      chk("mid_gnt", slv_gnt, 1);
      #2;
      Reset = 1'b1;
      #1;
      chk("rst_mid_gnt", slv_gnt, 0);
      chk("rst_mid_we", mem_we, 0);
      chk("rst_mid_busy", Busy, 1);
      chk("rst_mid_row", Row, 0);
      chk("rst_mid_col", Col, 0);
      chk("rst_mid_cell", CellValue, 0);
      @(negedge board_clk);
      slv_req = 1'b0;
      #1;
      chk("rst_mid_rvalid", slv_rvalid, 0);
      @(negedge board_clk);
      Reset = 1'b0;
      check_clear();

      idle();
      chk("sb_drain", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/grid_access_ctrl.md
GRID_ACCESS_CTRL -- requirements
Module: grid_access_ctrl

Interface
REQ-001 board_clk  in  1  system clock, 100 MHz, all state updates on rising edge.
REQ-002 Reset  in  1  asynchronous, active-high reset.
REQ-003 Prev, Next, Enter, Start  in  1 each  single-cycle debounced pulses: cursor back, cursor forward, write cell, start solve.
REQ-004 InputValue  in  4  value to write at the cursor; legal range 0..9, where 0 means empty.
REQ-005 slv_req, slv_we  in  1 each  solver port request, and solver write enable.
REQ-006 slv_addr  in  7  solver cell address, 0..80; slv_wdata  in  4  solver write data.
REQ-007 slv_gnt  out  1  solver owns the memory port this cycle.
REQ-008 slv_rdata  out  4  solver read data; slv_rvalid  out  1  slv_rdata valid.
REQ-009 mem_we  out  1  and mem_addr  out  7  grid RAM write enable and address.
REQ-010 mem_wdata  out  4  grid RAM write data; mem_rdata  in  4  grid RAM read data.
REQ-011 solve_go  out  1  one-cycle pulse that starts the solver; solve_done  in  1  solver finished (level or pulse).
REQ-012 Row, Col  out  4 each  cursor position 0..8; CellValue  out  4  grid value at the cursor.
REQ-013 Busy  out  1  high in CLEAR and SOLVE; InErr  out  1  one-cycle pulse on an illegal entry.

Function
REQ-014 The FSM SHALL have exactly four states: CLEAR, EDIT, SOLVE, VIEW.
REQ-015 CLEAR SHALL drive mem_we=1, mem_wdata=0, and mem_addr counting 0..80, one address per cycle (81 cycles), then go to EDIT.
REQ-016 In CLEAR, Prev, Next, Enter and Start SHALL be ignored.
REQ-017 The cursor linear address SHALL be Row*9+Col and SHALL be kept as a registered counter, not computed by a multiplier.
REQ-018 In EDIT and VIEW, Next SHALL advance Col; at Col=8, Col wraps to 0 and Row increments; at (8,8), the cursor wraps to (0,0).
REQ-019 In EDIT and VIEW, Prev SHALL move the cursor the reverse way; at (0,0), the cursor wraps to (8,8).
REQ-020 If Prev and Next are both high in the same cycle, the cursor SHALL NOT move.
REQ-021 In EDIT, Enter with InputValue<=9 SHALL write InputValue at the current cursor address in the same cycle (mem_we=1).
REQ-022 In EDIT, Enter with InputValue>9 SHALL NOT write and SHALL pulse InErr for one cycle.
REQ-023 If Enter and a cursor move occur in the same cycle, the write SHALL use the pre-move address; the move takes effect next cycle.
REQ-024 Whenever the UI owns the port and is not writing, mem_addr SHALL equal the cursor address and mem_we=0.
REQ-025 The RAM has one-cycle synchronous read; CellValue SHALL register mem_rdata, giving 2-cycle latency from a cursor change.
REQ-026 CellValue SHALL hold its value while a write or a solver access is in progress.
REQ-027 Start in EDIT SHALL pulse solve_go for exactly one cycle and enter SOLVE.
REQ-028 In SOLVE: slv_gnt=slv_req; when granted, mem_we=slv_we, mem_addr=slv_addr, mem_wdata=slv_wdata.
REQ-029 When the solver is granted and slv_we=0, slv_rvalid SHALL assert one cycle later with slv_rdata=mem_rdata.
REQ-030 slv_gnt SHALL be 0 outside SOLVE.
REQ-031 In SOLVE, Prev, Next, Enter and Start SHALL be ignored.
REQ-032 solve_done in SOLVE SHALL move to VIEW; the cursor is unchanged.
REQ-033 In VIEW, Enter SHALL be ignored, Prev and Next browse the grid, and Start SHALL return to EDIT with the grid contents retained.
REQ-034 solve_done outside SOLVE SHALL be ignored.
REQ-035 A slv_addr>80 SHALL be forwarded unchanged; no error handling is required.

Reset
REQ-036 Asserting Reset SHALL asynchronously force state=CLEAR, clear counter=0, Row=0, Col=0, CellValue=0.
REQ-037 Reset SHALL also force solve_go=0, slv_gnt=0, slv_rvalid=0, InErr=0, mem_we=0, and Busy=1.
REQ-038 Reset asserted mid-SOLVE or mid-CLEAR SHALL abandon the operation; after release, a full 81-cycle CLEAR runs.

Structure
REQ-039 Package sudoku_pkg SHALL hold: the state encoding, N=9, CELLS=81, ADDR_W=7, VAL_W=4, and EMPTY=0.
REQ-040 The Row/Col/linear-address wrap counter SHALL be a sub-module grid_cursor (inputs inc, dec; outputs row, col, addr).
REQ-041 The port multiplexer and the FSM SHALL live in grid_access_ctrl.

Verification
REQ-042 Release Reset -> mem_we=1 for exactly 81 cycles, addresses 0..80, data 0, Busy=1; then EDIT with Busy=0.
REQ-043 EDIT at (0,0): 80 Next pulses -> (8,8) with addr 80; one more Next -> (0,0); one Prev -> (8,8).
REQ-044 Cursor at (2,3), InputValue=7, Enter -> write at addr 21 with data 7; InputValue=12, Enter -> no write and InErr pulses.
REQ-045 Start -> one solve_go pulse; solver reads addr 21 -> slv_gnt=1, slv_rvalid and slv_rdata=7 one cycle later; Enter and Next ignored.
REQ-046 solve_done -> VIEW; Enter ignored, Next browses; Start -> EDIT with grid intact.
REQ-047 Reset mid-SOLVE with slv_req=1 -> slv_gnt drops immediately and a full CLEAR follows.
